fetch_debug_ctrl: RTL

Debug-side controller for the fetch stage. It assembles instruction words from a byte stream (UART RX), writes them into instruction memory through the fetch stage's debug write path, and then sequences execution in continuous or single-step mode by driving the fetch stall and the instruction-memory address select. It sits between the UART receiver and FETCH, and also observes the pipeline's halt indication.

---
 rtl/fetch_debug_ctrl_pkg.sv | 53 +++++
 rtl/fetch_debug_ctrl_byte_to_word.sv | 34 +++
 rtl/fetch_debug_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_debug_ctrl_pkg.sv
// Shared definitions for the fetch debug controller: state encoding,
// UART command bytes, halt opcode and the per-state output decode.
package fetch_debug_ctrl_pkg;

    localparam int unsigned DEFAULT_ADDR_W    = 10;
    localparam int unsigned DEFAULT_MEM_SIZEB = 1024;

    localparam logic [31:0] HALT_OPCODE = 32'hFC00_0000;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RUN     = 3'd3,
        ST_STEP    = 3'd4,
        ST_STEP_GO = 3'd5,
        ST_DONE    = 3'd6
    } dbg_state_e;

    typedef struct packed {
        logic fetch_stall;
        logic debug_unit;
        logic mem_ren;
        logic mem_wen;
        logic done;
    } dbg_outs_t;

    // Control outputs that belong to a state. The imem read port is released
    // while the debug path owns the address (LOAD/WRITE).
    function automatic dbg_outs_t state_outputs(input dbg_state_e st);
        dbg_outs_t o;
        o = '{fetch_stall: 1'b1, debug_unit: 1'b0, mem_ren: 1'b1,
              mem_wen: 1'b0, done: 1'b0};
        case (st)
            ST_IDLE:    o = o;
            ST_LOAD:    begin o.debug_unit = 1'b1; o.mem_ren = 1'b0; end
            ST_WRITE:   begin o.debug_unit = 1'b1; o.mem_ren = 1'b0; o.mem_wen = 1'b1; end
            ST_RUN:     o.fetch_stall = 1'b0;
            ST_STEP:    o = o;
            ST_STEP_GO: o.fetch_stall = 1'b0;
            ST_DONE:    o.done = 1'b1;
            default:    o = o;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fetch_debug_ctrl_byte_to_word.sv
// Four-byte MSB-first assembler. The fourth byte is not stored: it is
// combined on the fly so the owner can capture the full word in the same
// cycle that word_ready is raised.
module byte_to_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift_r;
    logic [1:0]  count_r;

    assign word       = {shift_r, byte_data};
    assign word_ready = byte_valid && (count_r == 2'd3);

    // Shift register and byte counter; clear discards any partial word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_r <= 24'd0;
            count_r <= 2'd0;
        end else if (byte_valid) begin
            shift_r <= {shift_r[15:0], byte_data};
            count_r <= count_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/fetch_debug_ctrl.sv
// Debug controller for the fetch stage: loads a program from the UART byte
// stream into instruction memory, then runs it continuously or step by step.
module fetch_debug_ctrl
    import fetch_debug_ctrl_pkg::*;
#(
    parameter int unsigned NB_INST   = 32,
    parameter int unsigned NB_ADDR   = DEFAULT_ADDR_W,
    parameter int unsigned MEM_SIZEB = DEFAULT_MEM_SIZEB,
    parameter logic [NB_INST-1:0] HALT_WORD = HALT_OPCODE
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_halt_seen,
    output logic               o_debug_unit,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_INST-1:0] o_mem_data,
    output logic               o_mem_wen,
    output logic               o_mem_ren,
    output logic               o_fetch_stall,
    output logic               o_loaded,
    output logic               o_overflow,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_SIZEB - 32'd4);
    localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(3'd4);

    dbg_state_e         state_r;
    dbg_state_e         state_next_s;
    dbg_outs_t          outs_next_s;
    logic [NB_ADDR-1:0] wr_addr_r;
    logic [NB_INST-1:0] mem_data_r;
    logic               loaded_r;
    logic               overflow_r;
    logic               stall_r;
    logic               debug_unit_r;
    logic               mem_wen_r;
    logic               mem_ren_r;
    logic               done_r;
    logic               load_byte_s;
    logic               start_load_s;
    logic               clear_s;
    logic [31:0]        word_s;
    logic               word_ready_s;
    logic               is_halt_s;
    logic               at_last_s;

    assign load_byte_s  = i_rx_valid && (state_r == ST_LOAD);
    assign start_load_s = (state_r == ST_IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
    // The counter restarts for every new word, both at load start and after each write.
    assign clear_s      = start_load_s || (state_r == ST_WRITE);
    // During WRITE the captured word sits in mem_data_r.
    assign is_halt_s    = (mem_data_r == HALT_WORD);
    assign at_last_s    = (wr_addr_r == LAST_ADDR);

    byte_to_word u_byte_to_word (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (clear_s),
        .byte_valid (load_byte_s),
        .byte_data  (i_rx_data),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode from commands, word completion and pipeline halt.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!i_rx_valid) begin
                    state_next_s = ST_IDLE;
                end else if (i_rx_data == CMD_LOAD) begin
                    state_next_s = ST_LOAD;
                end else if ((i_rx_data == CMD_RUN) && loaded_r) begin
                    state_next_s = ST_RUN;
                end else if ((i_rx_data == CMD_STEP) && loaded_r) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (word_ready_s) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (is_halt_s || at_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_halt_seen) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (i_halt_seen) begin
                    state_next_s = ST_DONE;
                end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
                    state_next_s = ST_STEP_GO;
                end else if (i_rx_valid && (i_rx_data == CMD_EXIT)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            ST_STEP_GO: begin
                if (i_halt_seen) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
            ST_DONE:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs line up with it.
    always_comb begin
        outs_next_s = state_outputs(state_next_s);
    end

    // Control output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_r      <= 1'b1;
            debug_unit_r <= 1'b0;
            mem_ren_r    <= 1'b1;
            mem_wen_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            stall_r      <= outs_next_s.fetch_stall;
            debug_unit_r <= outs_next_s.debug_unit;
            mem_ren_r    <= outs_next_s.mem_ren;
            mem_wen_r    <= outs_next_s.mem_wen;
            done_r       <= outs_next_s.done;
        end
    end

    // Write address and load status: reset on load start, updated as each write retires.
    always_ff @(posedge i_clk) begin
        if (i_reset || start_load_s) begin
            wr_addr_r  <= '0;
            loaded_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else if (state_r == ST_WRITE) begin
            if (is_halt_s) begin
                loaded_r <= 1'b1;
            end else if (at_last_s) begin
                overflow_r <= 1'b1;
            end else begin
                wr_addr_r <= wr_addr_r + WORD_STEP;
            end
        end else begin
            wr_addr_r  <= wr_addr_r;
            loaded_r   <= loaded_r;
            overflow_r <= overflow_r;
        end
    end

    // Capture the assembled word together with its fourth byte.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_data_r <= '0;
        end else if (word_ready_s) begin
            mem_data_r <= NB_INST'(word_s);
        end else begin
            mem_data_r <= mem_data_r;
        end
    end

    assign o_fetch_stall = stall_r;
    assign o_debug_unit  = debug_unit_r;
    assign o_mem_ren     = mem_ren_r;
    assign o_mem_wen     = mem_wen_r;
    assign o_done        = done_r;
    assign o_wr_addr     = wr_addr_r;
    assign o_mem_data    = mem_data_r;
    assign o_loaded      = loaded_r;
    assign o_overflow    = overflow_r;

endmodule
